sram_stream_ctrl: RTL

//  Byte-stream front end for the 512x8 single-port SRAM macro in chip_core.
//  - Upstream: pad-side byte producer pushes write bytes over valid/ready.
//  - Downstream: pad-side consumer pulls read bursts over valid/ready.
//  - Appends writes at an auto-incrementing pointer.
//  - Serves read bursts (base, length) at 1 byte/cycle, using a 2-entry skid buffer to absorb the macro's 1-cycle latency.

---
 rtl/sram_stream_pkg.sv | 18 +
 rtl/sram_stream_ctrl_if.sv | 36 +++
 rtl/sram_stream_ctrl_skid_buf2.sv | 48 ++++
 rtl/sram_stream_ctrl.sv | 133 +++++++++++++
 4 files changed

// File: rtl/sram_stream_pkg.sv
// rtl/sram_stream_pkg.sv - shared widths, FSM states and idle macro drive values
package sram_stream_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 8;
    localparam int LEN_W  = 10;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } state_e;

    localparam logic              SRAM_CEN_IDLE  = 1'b1;
    localparam logic              SRAM_GWEN_IDLE = 1'b1;
    localparam logic [DATA_W-1:0] SRAM_WEN_IDLE  = '1;

endpackage

// File: rtl/sram_stream_ctrl_if.sv
// rtl/sram_stream_ctrl_if.sv - pad-side byte streams plus SRAM macro pins
interface sram_stream_ctrl_if;
    import sram_stream_pkg::*;

    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              wr_clr;
    logic [ADDR_W-1:0] wr_ptr;
    logic              rd_start;
    logic [ADDR_W-1:0] rd_base;
    logic [LEN_W-1:0]  rd_len;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              sram_cen;
    logic              sram_gwen;
    logic [DATA_W-1:0] sram_wen;
    logic [ADDR_W-1:0] sram_a;
    logic [DATA_W-1:0] sram_d;
    logic [DATA_W-1:0] sram_q;

    modport master (
        output wr_valid, wr_data, wr_clr, rd_start, rd_base, rd_len, rd_ready, sram_q,
        input  wr_ready, wr_ptr, rd_valid, rd_data, busy,
               sram_cen, sram_gwen, sram_wen, sram_a, sram_d
    );

    modport slave (
        input  wr_valid, wr_data, wr_clr, rd_start, rd_base, rd_len, rd_ready, sram_q,
        output wr_ready, wr_ptr, rd_valid, rd_data, busy,
               sram_cen, sram_gwen, sram_wen, sram_a, sram_d
    );

endinterface

// File: rtl/sram_stream_ctrl_skid_buf2.sv
// rtl/sram_stream_ctrl_skid_buf2.sv - 2-entry valid/ready FIFO with registered head
module skid_buf2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] mem_q [2];
    logic         wptr_q;
    logic         rptr_q;
    logic [1:0]   count_q;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop_i && (count_q != 2'd0);
    assign do_push = push_i && ((count_q != 2'd2) || do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wptr_q   <= 1'b0;
            rptr_q   <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= push_data_i;
                wptr_q        <= ~wptr_q;
            end
            if (do_pop) begin
                rptr_q <= ~rptr_q;
            end
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign valid_o = (count_q != 2'd0);
    assign data_o  = mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/sram_stream_ctrl.sv
// rtl/sram_stream_ctrl.sv - byte-stream front end for the 512x8 single-port SRAM macro
module sram_stream_ctrl
    import sram_stream_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    sram_stream_ctrl_if.slave  bus
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [LEN_W-1:0]  left_q, left_d;
    logic              inflight_q;

    logic              wr_ready;
    logic              wr_acc;
    logic              start_acc;
    logic              pop;
    logic              issue;
    logic [2:0]        outstanding;
    logic [1:0]        buf_count;
    logic              buf_valid;
    logic [DATA_W-1:0] buf_data;

    logic              sram_cen, sram_gwen;
    logic [DATA_W-1:0] sram_wen, sram_d;
    logic [ADDR_W-1:0] sram_a;

    assign wr_ready  = rst_n && (state_q == IDLE) && !bus.rd_start;
    assign wr_acc    = bus.wr_valid && wr_ready;
    assign start_acc = rst_n && (state_q == IDLE) && bus.rd_start && (bus.rd_len != '0);
    assign pop       = buf_valid && bus.rd_ready;

    // A same-cycle pop frees a slot, which keeps the issue rate at one per cycle.
    assign outstanding = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue       = rst_n && (state_q == READ) && (left_q != '0) && (outstanding < 3'd2);

    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        left_d    = left_q;
        wr_ptr_d  = wr_ptr_q;

        if (bus.wr_clr) begin
            wr_ptr_d = '0;
        end else if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (start_acc) begin
                    state_d   = READ;
                    rd_addr_d = bus.rd_base;
                    left_d    = bus.rd_len;
                end
            end
            READ: begin
                if (issue) begin
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                    left_d    = left_q - LEN_W'(1);
                    if (left_q == LEN_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!inflight_q && ((buf_count == 2'd0) || ((buf_count == 2'd1) && pop))) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sram_cen  = SRAM_CEN_IDLE;
        sram_gwen = SRAM_GWEN_IDLE;
        sram_wen  = SRAM_WEN_IDLE;
        sram_a    = '0;
        sram_d    = '0;
        if (wr_acc) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = '0;
            sram_a    = wr_ptr_q;
            sram_d    = bus.wr_data;
        end else if (issue) begin
            sram_cen  = 1'b0;
            sram_a    = rd_addr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_addr_q  <= '0;
            left_q     <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_addr_q  <= rd_addr_d;
            left_q     <= left_d;
            inflight_q <= issue;
        end
    end

    skid_buf2 #(.W(DATA_W)) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (inflight_q),
        .push_data_i (bus.sram_q),
        .pop_i       (pop),
        .valid_o     (buf_valid),
        .data_o      (buf_data),
        .count_o     (buf_count)
    );

    assign bus.wr_ready  = wr_ready;
    assign bus.wr_ptr    = wr_ptr_q;
    assign bus.rd_valid  = buf_valid;
    assign bus.rd_data   = buf_data;
    assign bus.busy      = (state_q != IDLE);
    assign bus.sram_cen  = sram_cen;
    assign bus.sram_gwen = sram_gwen;
    assign bus.sram_wen  = sram_wen;
    assign bus.sram_a    = sram_a;
    assign bus.sram_d    = sram_d;

endmodule
